// File: rtl/change_disp_pkg.sv
// Shared types and defaults for the coin change dispenser.
package change_disp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Default denominations, index 0 (lowest bits) is the largest: 25,10,5,1
  localparam logic [31:0] DEF_COIN_VAL = {8'd1, 8'd5, 8'd10, 8'd25};

  // Width needed to index n denominations (at least 1 bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coin_change_dispenser_coin_select.sv
// Combinational priority picker: largest denomination that fits the remaining
// amount and still has stock.
module coin_select
  import change_disp_pkg::*;
#(
  parameter int unsigned AMT_W     = 8,
  parameter int unsigned NUM_COINS = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned IDX_W     = idx_width(NUM_COINS),
  parameter logic [NUM_COINS*AMT_W-1:0] COIN_VAL = DEF_COIN_VAL
) (
  input  logic [AMT_W-1:0]           remaining_i,
  input  logic [NUM_COINS*CNT_W-1:0] inv_i,
  output logic                       hit_o,
  output logic [NUM_COINS-1:0]       sel_o,
  output logic [IDX_W-1:0]           idx_o
);

  // Lowest index wins; later candidates are masked once a hit is found
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if (!hit_o &&
          (COIN_VAL[i*AMT_W +: AMT_W] <= remaining_i) &&
          (inv_i[i*CNT_W +: CNT_W] != '0)) begin
        hit_o    = 1'b1;
        sel_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Greedy coin change dispenser: accepts an amount, releases one coin per
// handshake (largest available first), tracks refillable inventory and
// reports the undispensable shortfall.
module coin_change_dispenser
  import change_disp_pkg::*;
#(
  parameter int unsigned AMT_W     = 8,
  parameter int unsigned NUM_COINS = 4,
  parameter int unsigned CNT_W     = 8,
  parameter logic [NUM_COINS*AMT_W-1:0] COIN_VAL = DEF_COIN_VAL,
  parameter logic [CNT_W-1:0] INIT_CNT = 8'd16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [AMT_W-1:0]               amt_i,
  input  logic                           amt_valid_i,
  output logic                           amt_ready_o,
  output logic                           coin_valid_o,
  output logic [NUM_COINS-1:0]           coin_sel_o,
  input  logic                           coin_ready_i,
  output logic                           done_o,
  output logic [AMT_W-1:0]               shortfall_o,
  input  logic                           refill_valid_i,
  input  logic [idx_width(NUM_COINS)-1:0] refill_idx_i,
  input  logic [CNT_W-1:0]               refill_cnt_i,
  output logic [NUM_COINS*CNT_W-1:0]     inv_cnt_o
);

  localparam int unsigned IDX_W = idx_width(NUM_COINS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               r_state;
  logic [AMT_W-1:0]     r_remaining;
  logic [NUM_COINS-1:0] r_sel;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_inv [NUM_COINS];

  logic                       w_hit;
  logic [NUM_COINS-1:0]       w_sel;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_coin_hs;
  logic [AMT_W-1:0]           w_coin_val;
  logic [NUM_COINS*CNT_W-1:0] w_inv_flat;
  logic [CNT_W-1:0]           w_add      [NUM_COINS];
  logic [CNT_W:0]             w_sum      [NUM_COINS];
  logic [CNT_W-1:0]           w_inv_next [NUM_COINS];

  assign w_coin_hs  = (r_state == DISPENSE) && coin_ready_i;
  assign w_coin_val = COIN_VAL[r_idx*AMT_W +: AMT_W];

  assign amt_ready_o  = (r_state == IDLE);
  assign coin_valid_o = (r_state == DISPENSE);
  assign coin_sel_o   = (r_state == DISPENSE) ? r_sel : '0;
  assign done_o       = (r_state == DONE);
  assign shortfall_o  = (r_state == DONE) ? r_remaining : '0;
  assign inv_cnt_o    = w_inv_flat;

  coin_select #(
    .AMT_W     (AMT_W),
    .NUM_COINS (NUM_COINS),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W),
    .COIN_VAL  (COIN_VAL)
  ) u_coin_select (
    .remaining_i (r_remaining),
    .inv_i       (w_inv_flat),
    .hit_o       (w_hit),
    .sel_o       (w_sel),
    .idx_o       (w_idx)
  );

  // Pack the inventory array onto the flat output bus
  always_comb begin
    w_inv_flat = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      w_inv_flat[i*CNT_W +: CNT_W] = r_inv[i];
    end
  end

  // Merge refill and dispense per counter; one extra bit catches saturation.
  // A dispensed counter is never zero, so the decrement cannot underflow.
  always_comb begin
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      w_add[i]      = (refill_valid_i && (32'(refill_idx_i) == i)) ? refill_cnt_i : '0;
      w_sum[i]      = {1'b0, r_inv[i]} + {1'b0, w_add[i]}
                    - {{CNT_W{1'b0}}, (w_coin_hs && r_sel[i])};
      w_inv_next[i] = w_sum[i][CNT_W] ? CNT_MAX : w_sum[i][CNT_W-1:0];
    end
  end

  // Inventory counters, reloaded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
        r_inv[i] <= INIT_CNT;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
        r_inv[i] <= w_inv_next[i];
      end
    end
  end

  // Transaction FSM with remaining amount and latched coin selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_sel       <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (amt_valid_i) begin
            r_remaining <= amt_i;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          if (w_hit) begin
            r_sel   <= w_sel;
            r_idx   <= w_idx;
            r_state <= DISPENSE;
          end else begin
            r_state <= DONE;
          end
        end
        DISPENSE: begin
          if (coin_ready_i) begin
            r_remaining <= r_remaining - w_coin_val;
            r_state     <= SELECT;
          end
        end
        DONE: begin
          r_remaining <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
